// File: rtl/openofdm_rx_byte_packer.sv
// -----------------------------------------------------------------------------
// openofdm_rx_byte_packer
//
// Packs the decoded openofdm_rx byte stream into 64-bit little-endian words for
// the host RX DMA. Each accepted packet is framed as:
//   header word, data words (partial last word zero-padded), status word (tlast).
// Words leave through a first-word-fall-through FIFO on an AXI-Stream-style
// master port.
//
// Ports:
//   clk, rstn                 clock, asynchronous active-low reset
//   pkt_header_valid_strobe   one-cycle header strobe, qualified by pkt_header_valid
//   pkt_rate, pkt_len, ht_aggr decoded header fields captured into the header word
//   byte_in_strobe, byte_in   decoded payload byte
//   fcs_in_strobe, fcs_ok     end of packet and FCS result
//   m_axis_*                  packed word stream (tlast marks the status word)
//   overflow_sticky           set whenever a word is discarded for lack of space
//   pkt_drop_cnt              saturating count of discarded headers
//
// Optional build macro: OPENOFDM_RX_PACKER_TIMESTAMP_EN
//   Defined   : header [31:0] carries a free-running 32-bit cycle count sampled
//               at the header strobe and ht_aggr moves to bit [32].
//   Undefined : header [31:0] = {15'b0, ht_aggr, 16'b0}.
// -----------------------------------------------------------------------------
module openofdm_rx_byte_packer #(
  parameter int FIFO_ADDR_WIDTH = 4,
  parameter int CNT_WIDTH       = 16
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 pkt_header_valid_strobe,
  input  logic                 pkt_header_valid,
  input  logic [7:0]           pkt_rate,
  input  logic [15:0]          pkt_len,
  input  logic                 ht_aggr,
  input  logic                 byte_in_strobe,
  input  logic [7:0]           byte_in,
  input  logic                 fcs_in_strobe,
  input  logic                 fcs_ok,
  output logic [63:0]          m_axis_tdata,
  output logic                 m_axis_tvalid,
  input  logic                 m_axis_tready,
  output logic                 m_axis_tlast,
  output logic                 overflow_sticky,
  output logic [CNT_WIDTH-1:0] pkt_drop_cnt
);

  localparam int DEPTH = 1 << FIFO_ADDR_WIDTH;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_DATA   = 2'd1;
  localparam logic [1:0] S_CLOSE  = 2'd2;
  localparam logic [1:0] S_STATUS = 2'd3;

  logic [1:0]           state;
  logic [63:0]          acc;
  logic [2:0]           lane;
  logic [CNT_WIDTH-1:0] byte_cnt;
  logic [15:0]          byte_cnt16;
  logic                 trunc_flag;
  logic                 abort_flag;
  logic                 fcs_flag;
  logic                 pend_valid;
  logic [63:0]          pend_word;

  logic                 hdr;
  logic [63:0]          new_hdr_word;
  logic [63:0]          byte_word;
  logic [63:0]          status_word;
  logic                 push_req;
  logic [63:0]          push_word;
  logic                 push_last;
  logic                 push_fire;
  logic                 can_push;
  logic                 pop;
  logic                 drop_inc;

  logic [64:0]                mem [DEPTH];
  logic [FIFO_ADDR_WIDTH-1:0] wr_ptr;
  logic [FIFO_ADDR_WIDTH-1:0] rd_ptr;
  logic [FIFO_ADDR_WIDTH:0]   fifo_cnt;
  logic [64:0]                head;

  assign hdr = pkt_header_valid_strobe & pkt_header_valid;

`ifdef OPENOFDM_RX_PACKER_TIMESTAMP_EN
  logic [31:0] ts_cnt;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) ts_cnt <= '0;
    else       ts_cnt <= ts_cnt + 32'd1;
  end

  // The marker keeps its upper seven bits; bit 32 carries ht_aggr instead.
  assign new_hdr_word = {pkt_len, pkt_rate, 7'b1010010, ht_aggr, ts_cnt};
`else
  assign new_hdr_word = {pkt_len, pkt_rate, 8'hA5, 15'd0, ht_aggr, 16'd0};
`endif

  // acc is kept zero in lanes not yet written, so OR-ing in the new lane
  // also yields the correctly padded partial word.
  assign byte_word   = acc | (64'(byte_in) << {lane, 3'b000});
  assign byte_cnt16  = 16'(byte_cnt);
  assign status_word = {8'h5A, 8'h00, byte_cnt16, 29'd0, trunc_flag, abort_flag, fcs_flag};

  // A full FIFO still accepts a word in the cycle the head is popped.
  assign pop       = m_axis_tvalid & m_axis_tready;
  assign can_push  = !fifo_cnt[FIFO_ADDR_WIDTH] || pop;
  assign push_fire = push_req & can_push;

  // Selects the single word (if any) the packer wants to write this cycle.
  always_comb begin
    push_req  = 1'b0;
    push_word = '0;
    push_last = 1'b0;
    case (state)
      S_IDLE: begin
        if (pend_valid || hdr) begin
          push_req  = 1'b1;
          push_word = pend_valid ? pend_word : new_hdr_word;
        end
      end
      S_DATA: begin
        if (!hdr && !fcs_in_strobe && byte_in_strobe && lane == 3'd7) begin
          push_req  = 1'b1;
          push_word = byte_word;
        end
      end
      S_CLOSE: begin
        push_req  = 1'b1;
        push_word = acc;
      end
      S_STATUS: begin
        push_req  = 1'b1;
        push_word = status_word;
        push_last = 1'b1;
      end
      default: ;
    endcase
  end

  // Headers are lost either when they cannot be written in IDLE or when a
  // newer header overwrites one still waiting in the pending register.
  assign drop_inc = (state == S_IDLE) ? ((pend_valid || hdr) && !can_push)
                                      : (hdr && pend_valid);

  // Packet framing state machine.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state           <= S_IDLE;
      acc             <= '0;
      lane            <= '0;
      byte_cnt        <= '0;
      trunc_flag      <= 1'b0;
      abort_flag      <= 1'b0;
      fcs_flag        <= 1'b0;
      pend_valid      <= 1'b0;
      pend_word       <= '0;
      overflow_sticky <= 1'b0;
      pkt_drop_cnt    <= '0;
    end else begin
      if (drop_inc && pkt_drop_cnt != '1)
        pkt_drop_cnt <= pkt_drop_cnt + CNT_WIDTH'(1);

      // Outside IDLE a new header waits until the current packet is closed.
      if (state != S_IDLE && hdr) begin
        pend_valid <= 1'b1;
        pend_word  <= new_hdr_word;
      end

      case (state)
        S_IDLE: begin
          if (pend_valid || hdr) begin
            if (pend_valid && hdr) pend_word  <= new_hdr_word;
            else                   pend_valid <= 1'b0;
            if (can_push) begin
              state      <= S_DATA;
              acc        <= '0;
              lane       <= '0;
              byte_cnt   <= '0;
              trunc_flag <= 1'b0;
              abort_flag <= 1'b0;
              fcs_flag   <= 1'b0;
            end else begin
              overflow_sticky <= 1'b1;
            end
          end
        end
        S_DATA: begin
          if (hdr) begin
            abort_flag <= 1'b1;
            fcs_flag   <= 1'b0;
            state      <= (lane != 3'd0) ? S_CLOSE : S_STATUS;
          end else if (fcs_in_strobe) begin
            fcs_flag <= fcs_ok;
            state    <= (lane != 3'd0) ? S_CLOSE : S_STATUS;
          end else if (byte_in_strobe) begin
            if (byte_cnt != '1) byte_cnt <= byte_cnt + CNT_WIDTH'(1);
            lane <= lane + 3'd1;
            if (lane == 3'd7) begin
              acc <= '0;
              if (!can_push) begin
                trunc_flag      <= 1'b1;
                overflow_sticky <= 1'b1;
              end
            end else begin
              acc <= byte_word;
            end
          end
        end
        S_CLOSE: begin
          acc   <= '0;
          lane  <= '0;
          state <= S_STATUS;
          if (!can_push) begin
            trunc_flag      <= 1'b1;
            overflow_sticky <= 1'b1;
          end
        end
        S_STATUS: begin
          // The status word is never dropped: hold here until it fits.
          if (can_push) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // FIFO storage; contents need no reset because tvalid gates every read.
  always_ff @(posedge clk) begin
    if (push_fire) mem[wr_ptr] <= {push_last, push_word};
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push_fire) wr_ptr <= wr_ptr + FIFO_ADDR_WIDTH'(1);
      if (pop)       rd_ptr <= rd_ptr + FIFO_ADDR_WIDTH'(1);
      case ({push_fire, pop})
        2'b10:   fifo_cnt <= fifo_cnt + (FIFO_ADDR_WIDTH+1)'(1);
        2'b01:   fifo_cnt <= fifo_cnt - (FIFO_ADDR_WIDTH+1)'(1);
        default: ;
      endcase
    end
  end

  assign head          = mem[rd_ptr];
  assign m_axis_tvalid = (fifo_cnt != '0);
  assign m_axis_tdata  = m_axis_tvalid ? head[63:0] : 64'd0;
  assign m_axis_tlast  = m_axis_tvalid & head[64];

endmodule

// File: tb/tb_openofdm_rx_byte_packer.sv
// -----------------------------------------------------------------------------
// tb_openofdm_rx_byte_packer
//
// Drives header/byte/FCS events into openofdm_rx_byte_packer and compares the
// output word stream against words built from the packet contents (header
// fields, bytes chunked into little-endian 64-bit words, status fields).
// -----------------------------------------------------------------------------
module tb_openofdm_rx_byte_packer;

  typedef logic [7:0] byte_q_t[$];

  localparam int EV_HDR     = 0;
  localparam int EV_BYTE    = 1;
  localparam int EV_FCS     = 2;
  localparam int EV_HDR_INV = 3;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        pkt_header_valid_strobe = 1'b0;
  logic        pkt_header_valid = 1'b0;
  logic [7:0]  pkt_rate = 8'd0;
  logic [15:0] pkt_len = 16'd0;
  logic        ht_aggr = 1'b0;
  logic        byte_in_strobe = 1'b0;
  logic [7:0]  byte_in = 8'd0;
  logic        fcs_in_strobe = 1'b0;
  logic        fcs_ok = 1'b0;
  logic [63:0] m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tready = 1'b0;
  logic        m_axis_tlast;
  logic        overflow_sticky;
  logic [15:0] pkt_drop_cnt;

  int          total = 0;
  int          bad = 0;
  int          extra_words = 0;
  logic [64:0] exp_q[$];
  logic        rand_ready = 1'b0;
  logic        fixed_ready = 1'b0;
  logic        prev_stall = 1'b0;
  logic [63:0] prev_data = 64'd0;

  openofdm_rx_byte_packer dut (
    .clk                     (clk),
    .rstn                    (rstn),
    .pkt_header_valid_strobe (pkt_header_valid_strobe),
    .pkt_header_valid        (pkt_header_valid),
    .pkt_rate                (pkt_rate),
    .pkt_len                 (pkt_len),
    .ht_aggr                 (ht_aggr),
    .byte_in_strobe          (byte_in_strobe),
    .byte_in                 (byte_in),
    .fcs_in_strobe           (fcs_in_strobe),
    .fcs_ok                  (fcs_ok),
    .m_axis_tdata            (m_axis_tdata),
    .m_axis_tvalid           (m_axis_tvalid),
    .m_axis_tready           (m_axis_tready),
    .m_axis_tlast            (m_axis_tlast),
    .overflow_sticky         (overflow_sticky),
    .pkt_drop_cnt            (pkt_drop_cnt)
  );

  always #5 clk = ~clk;

  // Downstream ready: either random or a fixed level, updated just after each edge.
  always @(posedge clk) begin
    #1;
    m_axis_tready = rand_ready ? ($urandom_range(3) != 0) : fixed_ready;
  end

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Output monitor: every transferred word is matched against the expected
  // stream, and a stalled word must stay put until taken.
  always @(negedge clk) begin
    logic [64:0] front;
    if (!rstn) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        checkOutput("hold_valid", 64'(m_axis_tvalid), 64'd1);
        checkOutput("hold_data", m_axis_tdata, prev_data);
      end
      if (m_axis_tvalid && m_axis_tready) begin
        if (exp_q.size() == 0) begin
          extra_words++;
        end else begin
          front = exp_q.pop_front();
          checkOutput("word_data", m_axis_tdata, front[63:0]);
          checkOutput("word_last", 64'(m_axis_tlast), 64'(front[64]));
        end
      end
      prev_stall = m_axis_tvalid && !m_axis_tready;
      prev_data  = m_axis_tdata;
    end
  end

  // One input event: a single-cycle strobe followed by idle cycles.
  task automatic applyStimulus(input int kind, input logic [15:0] len,
                               input logic [7:0] val, input logic flag);
    @(posedge clk); #1;
    case (kind)
      EV_HDR: begin
        pkt_header_valid_strobe = 1'b1; pkt_header_valid = 1'b1;
        pkt_len = len; pkt_rate = val; ht_aggr = flag;
      end
      EV_HDR_INV: begin
        pkt_header_valid_strobe = 1'b1; pkt_header_valid = 1'b0;
        pkt_len = len; pkt_rate = val; ht_aggr = flag;
      end
      EV_BYTE: begin
        byte_in_strobe = 1'b1; byte_in = val;
      end
      default: begin
        fcs_in_strobe = 1'b1; fcs_ok = flag;
      end
    endcase
    @(posedge clk); #1;
    pkt_header_valid_strobe = 1'b0;
    pkt_header_valid        = 1'b0;
    byte_in_strobe          = 1'b0;
    fcs_in_strobe           = 1'b0;
    repeat (3) @(posedge clk);
  endtask

  task automatic makeBytes(input int n, input bit seq, output byte_q_t b);
    b = {};
    for (int i = 0; i < n; i++) b.push_back(seq ? 8'(i + 1) : 8'($urandom_range(255)));
  endtask

  // Expected words of one packet; keep < 0 keeps every data word, otherwise
  // only the first keep data words survive and the packet reports truncation.
  task automatic modelPacket(input logic [7:0] rate, input logic aggr, input byte_q_t b,
                             input logic fcs, input logic aborted, input int keep);
    int          n = b.size();
    int          nw = (b.size() + 7) / 8;
    logic        trunc = 1'b0;
    logic [63:0] w;
    exp_q.push_back({1'b0, 16'(n), rate, 8'hA5, 15'd0, aggr, 16'd0});
    for (int i = 0; i < nw; i++) begin
      w = '0;
      for (int k = 0; k < 8; k++) if (i * 8 + k < n) w[8*k +: 8] = b[i * 8 + k];
      if (keep < 0 || i < keep) exp_q.push_back({1'b0, w});
      else trunc = 1'b1;
    end
    exp_q.push_back({1'b1, 8'h5A, 8'h00, 16'(n), 29'd0, trunc, aborted, aborted ? 1'b0 : fcs});
  endtask

  task automatic sendPacket(input logic [7:0] rate, input logic aggr, input byte_q_t b, input logic fcs);
    applyStimulus(EV_HDR, 16'(b.size()), rate, aggr);
    foreach (b[i]) applyStimulus(EV_BYTE, 16'd0, b[i], 1'b0);
    applyStimulus(EV_FCS, 16'd0, 8'd0, fcs);
  endtask

  task automatic waitDrain(input string tag);
    int cyc = 0;
    while (exp_q.size() != 0 && cyc < 5000) begin
      @(posedge clk);
      cyc++;
    end
    checkOutput({tag, "_left"}, 64'(exp_q.size()), 64'd0);
    exp_q.delete();
    repeat (10) @(posedge clk);
    checkOutput({tag, "_extra"}, 64'(extra_words), 64'd0);
    extra_words = 0;
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    byte_q_t b;
    byte_q_t b2;
    logic    f;

    // Reset state
    repeat (3) @(posedge clk);
    #2;
    checkOutput("rst_tvalid", 64'(m_axis_tvalid), 64'd0);
    checkOutput("rst_tdata", m_axis_tdata, 64'd0);
    checkOutput("rst_tlast", 64'(m_axis_tlast), 64'd0);
    checkOutput("rst_overflow", 64'(overflow_sticky), 64'd0);
    checkOutput("rst_drop", 64'(pkt_drop_cnt), 64'd0);
    rstn = 1'b1;
    fixed_ready = 1'b1;
    repeat (2) @(posedge clk);

    // Basic packet with literal expected words
    exp_q.push_back({1'b0, 64'h000A0BA5_00000000});
    exp_q.push_back({1'b0, 64'h08070605_04030201});
    exp_q.push_back({1'b0, 64'h00000000_00000A09});
    exp_q.push_back({1'b1, 64'h5A00000A_00000001});
    makeBytes(10, 1'b1, b);
    sendPacket(8'h0B, 1'b0, b, 1'b1);
    waitDrain("basic");

    // Unqualified header ignored, then exact multiple of 8 bytes, fcs bad
    applyStimulus(EV_HDR_INV, 16'd3, 8'h11, 1'b0);
    makeBytes(16, 1'b0, b);
    modelPacket(8'h2C, 1'b1, b, 1'b0, 1'b0, -1);
    sendPacket(8'h2C, 1'b1, b, 1'b0);
    waitDrain("exact16");

    // Abort: second header mid-packet, then the second packet completes
    makeBytes(5, 1'b0, b);
    makeBytes(3, 1'b0, b2);
    modelPacket(8'h07, 1'b0, b, 1'b1, 1'b1, -1);
    modelPacket(8'h09, 1'b1, b2, 1'b1, 1'b0, -1);
    applyStimulus(EV_HDR, 16'd5, 8'h07, 1'b0);
    foreach (b[i]) applyStimulus(EV_BYTE, 16'd0, b[i], 1'b0);
    applyStimulus(EV_HDR, 16'd3, 8'h09, 1'b1);
    foreach (b2[i]) applyStimulus(EV_BYTE, 16'd0, b2[i], 1'b0);
    applyStimulus(EV_FCS, 16'd0, 8'd0, 1'b1);
    waitDrain("abort");

    // Random packets under random downstream ready
    rand_ready = 1'b1;
    for (int p = 0; p < 6; p++) begin
      makeBytes($urandom_range(40), 1'b0, b);
      f = 1'($urandom_range(1));
      modelPacket(8'($urandom_range(255)), 1'(p & 1), b, f, 1'b0, -1);
      sendPacket(8'(exp_q[exp_q.size() - 2 - (b.size() + 7) / 8][47:40]), 1'(p & 1), b, f);
    end
    rand_ready = 1'b0;
    waitDrain("random");

    // Backpressure: 200 bytes with the sink stalled
    fixed_ready = 1'b0;
    repeat (3) @(posedge clk);
    makeBytes(200, 1'b1, b);
    modelPacket(8'h0D, 1'b0, b, 1'b1, 1'b0, 15);
    sendPacket(8'h0D, 1'b0, b, 1'b1);
    repeat (5) @(posedge clk);
    checkOutput("bp_overflow", 64'(overflow_sticky), 64'd1);
    checkOutput("bp_held", 64'(exp_q.size()), 64'd17);
    fixed_ready = 1'b1;
    waitDrain("backpressure");

    // Drop: FIFO exactly full in IDLE, then a header with bytes and FCS
    fixed_ready = 1'b0;
    repeat (3) @(posedge clk);
    makeBytes(112, 1'b0, b);
    modelPacket(8'h21, 1'b0, b, 1'b1, 1'b0, -1);
    sendPacket(8'h21, 1'b0, b, 1'b1);
    makeBytes(8, 1'b0, b2);
    sendPacket(8'h22, 1'b0, b2, 1'b1);
    checkOutput("drop_cnt", 64'(pkt_drop_cnt), 64'd1);
    checkOutput("drop_held", 64'(exp_q.size()), 64'd16);
    fixed_ready = 1'b1;
    waitDrain("drop");
    checkOutput("drop_cnt_after", 64'(pkt_drop_cnt), 64'd1);

    // Asynchronous reset mid-packet with a word waiting at the output
    fixed_ready = 1'b0;
    repeat (3) @(posedge clk);
    applyStimulus(EV_HDR, 16'd4, 8'h33, 1'b0);
    applyStimulus(EV_BYTE, 16'd0, 8'hAB, 1'b0);
    applyStimulus(EV_BYTE, 16'd0, 8'hCD, 1'b0);
    checkOutput("pre_rst_tvalid", 64'(m_axis_tvalid), 64'd1);
    @(posedge clk); #2;
    rstn = 1'b0;
    #1;
    checkOutput("arst_tvalid", 64'(m_axis_tvalid), 64'd0);
    checkOutput("arst_tdata", m_axis_tdata, 64'd0);
    checkOutput("arst_tlast", 64'(m_axis_tlast), 64'd0);
    checkOutput("arst_overflow", 64'(overflow_sticky), 64'd0);
    checkOutput("arst_drop", 64'(pkt_drop_cnt), 64'd0);
    exp_q.delete();
    @(posedge clk); #2;
    rstn = 1'b1;
    fixed_ready = 1'b1;
    repeat (2) @(posedge clk);
    makeBytes(10, 1'b1, b);
    modelPacket(8'h0B, 1'b1, b, 1'b1, 1'b0, -1);
    sendPacket(8'h0B, 1'b1, b, 1'b1);
    waitDrain("post_reset");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/openofdm_rx_byte_packer.md
Name: openofdm_rx_byte_packer

Overview:
Downstream consumer of the openofdm_rx decoded byte stream. It packs bytes into 64-bit little-endian words for the host-side RX DMA interface, framed by a header word and a status word per packet. Output is an AXI-Stream-style master port behind an internal FIFO. Handles overflow, truncation and aborted packets deterministically.

Parameters:
FIFO_ADDR_WIDTH, 4, log2 of FIFO depth in 64-bit words (default 16 entries)
CNT_WIDTH, 16, width of the byte counter and the drop counter

Ports:
clk  in  1  system clock (same domain as openofdm_rx)
rstn  in  1  asynchronous active-low reset
pkt_header_valid_strobe  in  1  one-cycle header decode strobe
pkt_header_valid  in  1  header valid; qualifies the strobe
pkt_rate  in  8  decoded rate/MCS
pkt_len  in  16  PSDU length in bytes
ht_aggr  in  1  HT aggregation flag
byte_in_strobe  in  1  decoded byte valid
byte_in  in  8  decoded byte
fcs_in_strobe  in  1  end-of-packet strobe
fcs_ok  in  1  FCS result, sampled with fcs_in_strobe
m_axis_tdata  out  64  packed word
m_axis_tvalid  out  1  word valid
m_axis_tready  in  1  downstream ready
m_axis_tlast  out  1  marks the status word
overflow_sticky  out  1  set on any dropped word; cleared by reset only
pkt_drop_cnt  out  CNT_WIDTH  headers dropped, saturating

Behaviour:
- Reset values:
  - All outputs 0.
  - FIFO empty; FSM in IDLE; accumulator, byte lane index and byte counter all 0.
- Input timing guarantee (upstream contract): byte_in_strobe and fcs_in_strobe are at least 3 cycles apart from any other strobe of either kind.
- Header strobe: with pkt_header_valid=0 it is ignored.
- FSM states: IDLE, DATA, CLOSE, STATUS.
- IDLE:
  - On a valid header: push the header word; go to DATA.
  - Header word: [63:48]=pkt_len, [47:40]=pkt_rate, [39:32]=8'hA5, [33]... reserved 0 except [40-] as listed, bit [16]=ht_aggr, [31:0] per Optional Feature.
  - If the FIFO is full: do not push, increment pkt_drop_cnt, stay in IDLE, ignore bytes and FCS until the next header.
- DATA:
  - Each byte is written to lane L, bits [8L+7:8L]; L increments; the byte counter increments and saturates.
  - When L wraps 7->0, the word is pushed.
- FCS strobe in DATA:
  - Latch fcs_ok.
  - If L!=0, go to CLOSE: push the partial word with unused lanes 0.
  - Then go to STATUS.
- STATUS: push the status word, then return to IDLE.
  - Status word: [63:56]=8'h5A, [47:32]=bytes received, [2]=truncated, [1]=aborted, [0]=fcs_ok latched; other bits 0.
  - It is the only word pushed with tlast=1.
- Valid header while in DATA (upstream reset mid-packet):
  - Close the current packet: partial word if any, then status with aborted=1 and fcs_ok=0.
  - Then push the new header; the new header is held in a one-entry pending register until then.
  - A second header arriving while one is pending replaces it and increments pkt_drop_cnt.
- FIFO full on a data or partial push:
  - Word discarded; truncated flag set for the packet; overflow_sticky set.
- FIFO full on a status push:
  - FSM stalls in STATUS until space is available; input bytes arriving meanwhile are discarded.
  - The stall is bounded by the input guarantee.
- Status push priority: the status word is always eventually written, so every accepted header produces exactly one tlast.
- FIFO:
  - First-word fall-through.
  - Push-to-tvalid latency 1 cycle.
  - Transfer on tvalid&tready; a simultaneous push and pop is legal when full.
  - tdata and tlast remain stable while tvalid=1 and tready=0.
- Bytes received while in IDLE or STATUS are ignored.

Optional Feature:
OPENOFDM_RX_PACKER_TIMESTAMP_EN
- Defined:
  - A 32-bit free-running cycle counter runs from reset (0) and wraps.
  - Its value at the header strobe cycle is placed in header word [31:0], with ht_aggr moved to [32].
- Undefined:
  - No counter is implemented.
  - Header word [31:0] = {15'b0, ht_aggr, 16'b0}, i.e. ht_aggr at bit [16].

Test Plan:
- Basic packet: header len=10 rate=0x0B; bytes 0x01..0x0A; fcs_ok=1; tready=1 -> 4 words:
  - Header 0x000A_0BA5_...
  - Data 0x0807060504030201
  - Data 0x0000000000000A09
  - Status 0x5A00_000A_0000_0001 with tlast=1.
- Exact multiple: 16 bytes then FCS with fcs_ok=0 -> header, 2 full data words, status bit0=0, no padded word.
- Backpressure: tready=0 throughout a 200-byte packet with depth 16 ->
  - overflow_sticky=1.
  - Status truncated=1, bytes=200; the status word is output once tready rises.
- Abort: header, 5 bytes, then a second header with no FCS ->
  - Partial word, status aborted=1, second header, all in order.
- Drop: FIFO full in IDLE and a header arrives -> pkt_drop_cnt=1; following bytes and FCS produce no words.
- Async reset mid-DATA with tvalid=1 -> tvalid=0 and the FIFO empties immediately; the next packet is framed correctly.
